// File: rtl/wormhole_ctrl.sv
// Wormhole controller: bounces the original wormhole horizontally, switches the
// cheat position at frame boundaries, and issues teleports with a frame cooldown.
module wormhole_ctrl #(
    parameter int X_MIN           = 64,
    parameter int X_MAX           = 544,
    parameter int Y_ORIG          = 200,
    parameter int STEP_X          = 4,
    parameter int MOVE_FRAMES     = 2,
    parameter int CHEAT_X         = 300,
    parameter int CHEAT_Y         = 400,
    parameter int DEST_X          = 320,
    parameter int DEST_Y          = 40,
    parameter int CHEAT_DEST_X    = 100,
    parameter int CHEAT_DEST_Y    = 40,
    parameter int COOLDOWN_FRAMES = 60
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               cheatKey,
    input  logic               collision,
    output logic signed [10:0] topLeftX_Original,
    output logic signed [10:0] topLeftY_Original,
    output logic signed [10:0] topLeftX_Cheat,
    output logic signed [10:0] topLeftY_Cheat,
    output logic               wormholeCheat,
    output logic               teleport,
    output logic signed [10:0] teleportX,
    output logic signed [10:0] teleportY
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TELEPORT = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    localparam logic signed [10:0] X_MIN_11      = 11'(X_MIN);
    localparam logic signed [10:0] X_MAX_11      = 11'(X_MAX);
    localparam logic signed [11:0] X_MIN_12      = 12'(X_MIN);
    localparam logic signed [11:0] X_MAX_12      = 12'(X_MAX);
    localparam logic signed [11:0] STEP_POS      = 12'(STEP_X);
    localparam logic signed [11:0] STEP_NEG      = 12'(-STEP_X);
    localparam logic [15:0]        FRAME_LAST    = 16'(MOVE_FRAMES - 1);
    localparam logic [15:0]        COOL_LOAD     = 16'(COOLDOWN_FRAMES);
    localparam logic signed [10:0] DEST_X_11     = 11'(DEST_X);
    localparam logic signed [10:0] DEST_Y_11     = 11'(DEST_Y);
    localparam logic signed [10:0] C_DEST_X_11   = 11'(CHEAT_DEST_X);
    localparam logic signed [10:0] C_DEST_Y_11   = 11'(CHEAT_DEST_Y);

    state_t              state_q, state_d;
    logic signed [10:0]  x_q, x_d;
    logic                dir_neg_q, dir_neg_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic [15:0]         cool_cnt_q, cool_cnt_d;
    logic                pending_q, pending_d;
    logic                key_q, key_d;
    logic                cheat_q, cheat_d;
    logic                teleport_q, teleport_d;
    logic signed [10:0]  tele_x_q, tele_x_d;
    logic signed [10:0]  tele_y_q, tele_y_d;

    logic                move;
    logic                key_rise;
    logic signed [11:0]  x_next;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        x_d         = x_q;
        dir_neg_d   = dir_neg_q;
        move        = 1'b0;

        if (startOfFrame) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d = '0;
                move        = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end

        // Sign-extend so the overshoot past either limit is seen before clamping.
        x_next = {x_q[10], x_q} + (dir_neg_q ? STEP_NEG : STEP_POS);

        if (move) begin
            if (x_next >= X_MAX_12) begin
                x_d       = X_MAX_11;
                dir_neg_d = 1'b1;
            end else if (x_next <= X_MIN_12) begin
                x_d       = X_MIN_11;
                dir_neg_d = 1'b0;
            end else begin
                x_d = x_next[10:0];
            end
        end
    end

    always_comb begin
        key_rise = cheatKey & ~key_q;
        key_d    = cheatKey;
        cheat_d  = cheat_q;
        // A key edge coinciding with the frame pulse lands in the next frame.
        if (startOfFrame) begin
            cheat_d   = cheat_q ^ pending_q;
            pending_d = key_rise;
        end else begin
            pending_d = pending_q ^ key_rise;
        end
    end

    always_comb begin
        state_d    = state_q;
        cool_cnt_d = cool_cnt_q;
        teleport_d = 1'b0;
        tele_x_d   = tele_x_q;
        tele_y_d   = tele_y_q;

        case (state_q)
            ST_IDLE: begin
                if (collision) begin
                    state_d    = ST_TELEPORT;
                    teleport_d = 1'b1;
                    tele_x_d   = cheat_d ? C_DEST_X_11 : DEST_X_11;
                    tele_y_d   = cheat_d ? C_DEST_Y_11 : DEST_Y_11;
                end
            end
            ST_TELEPORT: begin
                cool_cnt_d = COOL_LOAD;
                state_d    = ST_COOLDOWN;
            end
            ST_COOLDOWN: begin
                if (startOfFrame) begin
                    if (cool_cnt_q <= 16'd1) begin
                        cool_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        cool_cnt_d = cool_cnt_q - 16'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            state_q     <= ST_IDLE;
            x_q         <= X_MIN_11;
            dir_neg_q   <= 1'b0;
            frame_cnt_q <= '0;
            cool_cnt_q  <= '0;
            pending_q   <= 1'b0;
            key_q       <= 1'b0;
            cheat_q     <= 1'b0;
            teleport_q  <= 1'b0;
            tele_x_q    <= '0;
            tele_y_q    <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            dir_neg_q   <= dir_neg_d;
            frame_cnt_q <= frame_cnt_d;
            cool_cnt_q  <= cool_cnt_d;
            pending_q   <= pending_d;
            key_q       <= key_d;
            cheat_q     <= cheat_d;
            teleport_q  <= teleport_d;
            tele_x_q    <= tele_x_d;
            tele_y_q    <= tele_y_d;
        end
    end

    assign topLeftX_Original = x_q;
    assign topLeftY_Original = 11'(Y_ORIG);
    assign topLeftX_Cheat    = 11'(CHEAT_X);
    assign topLeftY_Cheat    = 11'(CHEAT_Y);
    assign wormholeCheat     = cheat_q;
    assign teleport          = teleport_q;
    assign teleportX         = tele_x_q;
    assign teleportY         = tele_y_q;

endmodule

// File: tb/tb_wormhole_ctrl.sv
// Directed bench for wormhole_ctrl: bounce, cheat toggle, teleport, cooldown, reset.
module tb_wormhole_ctrl;

    logic               clk = 1'b0;
    logic               resetN = 1'b1;
    logic               startOfFrame = 1'b0;
    logic               cheatKey = 1'b0;
    logic               collision = 1'b0;
    logic signed [10:0] topLeftX_Original;
    logic signed [10:0] topLeftY_Original;
    logic signed [10:0] topLeftX_Cheat;
    logic signed [10:0] topLeftY_Cheat;
    logic               wormholeCheat;
    logic               teleport;
    logic signed [10:0] teleportX;
    logic signed [10:0] teleportY;

    int total = 0;
    int bad   = 0;

    wormhole_ctrl #(.COOLDOWN_FRAMES(3)) dut (
        .clk               (clk),
        .resetN            (resetN),
        .startOfFrame      (startOfFrame),
        .cheatKey          (cheatKey),
        .collision         (collision),
        .topLeftX_Original (topLeftX_Original),
        .topLeftY_Original (topLeftY_Original),
        .topLeftX_Cheat    (topLeftX_Cheat),
        .topLeftY_Cheat    (topLeftY_Cheat),
        .wormholeCheat     (wormholeCheat),
        .teleport          (teleport),
        .teleportX         (teleportX),
        .teleportY         (teleportY)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        startOfFrame = 1'b0;
        cheatKey     = 1'b0;
        collision    = 1'b0;
        resetN       = 1'b1;
        tick();
        tick();
        resetN = 1'b0;
    endtask

    task automatic sof_pulse();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic key_pulse();
        cheatKey = 1'b1;
        tick();
        cheatKey = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (topLeftX_Original !== 11'sd64)  begin bad++; $display("FAIL reset_x got=%0d want=64", topLeftX_Original); end
        total++; if (topLeftY_Original !== 11'sd200) begin bad++; $display("FAIL reset_y got=%0d want=200", topLeftY_Original); end
        total++; if (topLeftX_Cheat !== 11'sd300)    begin bad++; $display("FAIL cheat_x got=%0d want=300", topLeftX_Cheat); end
        total++; if (topLeftY_Cheat !== 11'sd400)    begin bad++; $display("FAIL cheat_y got=%0d want=400", topLeftY_Cheat); end
        total++; if (wormholeCheat !== 1'b0)         begin bad++; $display("FAIL reset_cheat got=%0b want=0", wormholeCheat); end
        total++; if (teleport !== 1'b0)              begin bad++; $display("FAIL reset_tele got=%0b want=0", teleport); end
        total++; if (teleportX !== 11'sd0 || teleportY !== 11'sd0) begin
            bad++; $display("FAIL reset_dest got=(%0d,%0d) want=(0,0)", teleportX, teleportY);
        end
    endtask

    // Triangle wave: 120 moves up from 64 to 544, 120 moves back down.
    task automatic test_bounce();
        int m, p, exp_x;
        logic seen_max;
        do_reset();
        seen_max = 1'b0;
        for (int k = 1; k <= 500; k++) begin
            sof_pulse();
            m = k / 2;
            p = m % 240;
            exp_x = (p <= 120) ? 64 + 4 * p : 64 + 4 * (240 - p);
            total++;
            if (topLeftX_Original !== 11'(exp_x)) begin
                bad++; $display("FAIL bounce_x frame=%0d got=%0d want=%0d", k, topLeftX_Original, exp_x);
            end
            total++;
            if (topLeftX_Original < 11'sd64 || topLeftX_Original > 11'sd544) begin
                bad++; $display("FAIL bounce_range frame=%0d got=%0d want=64..544", k, topLeftX_Original);
            end
            if (topLeftX_Original == 11'sd544) seen_max = 1'b1;
            tick();
            tick();
        end
        total++; if (seen_max !== 1'b1) begin bad++; $display("FAIL bounce_max got=%0b want=1", seen_max); end
    endtask

    task automatic test_cheat_toggle();
        do_reset();
        tick();
        key_pulse();
        total++; if (wormholeCheat !== 1'b0) begin bad++; $display("FAIL cheat_midframe got=%0b want=0", wormholeCheat); end
        sof_pulse();
        total++; if (wormholeCheat !== 1'b1) begin bad++; $display("FAIL cheat_single got=%0b want=1", wormholeCheat); end
        key_pulse();
        tick();
        key_pulse();
        sof_pulse();
        total++; if (wormholeCheat !== 1'b1) begin bad++; $display("FAIL cheat_double got=%0b want=1", wormholeCheat); end
        cheatKey = 1'b1;
        repeat (4) tick();
        sof_pulse();
        total++; if (wormholeCheat !== 1'b0) begin bad++; $display("FAIL cheat_held1 got=%0b want=0", wormholeCheat); end
        repeat (4) tick();
        sof_pulse();
        total++; if (wormholeCheat !== 1'b0) begin bad++; $display("FAIL cheat_held2 got=%0b want=0", wormholeCheat); end
        cheatKey = 1'b0;
        tick();
        cheatKey     = 1'b1;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        cheatKey     = 1'b0;
        total++; if (wormholeCheat !== 1'b0) begin bad++; $display("FAIL cheat_same_sof got=%0b want=0", wormholeCheat); end
        tick();
        sof_pulse();
        total++; if (wormholeCheat !== 1'b1) begin bad++; $display("FAIL cheat_deferred got=%0b want=1", wormholeCheat); end
    endtask

    task automatic test_teleport();
        do_reset();
        tick();
        collision = 1'b1;
        tick();
        collision = 1'b0;
        total++; if (teleport !== 1'b1) begin bad++; $display("FAIL tele_pulse got=%0b want=1", teleport); end
        total++; if (teleportX !== 11'sd320 || teleportY !== 11'sd40) begin
            bad++; $display("FAIL tele_dest got=(%0d,%0d) want=(320,40)", teleportX, teleportY);
        end
        tick();
        total++; if (teleport !== 1'b0) begin bad++; $display("FAIL tele_width got=%0b want=0", teleport); end
        total++; if (teleportX !== 11'sd320 || teleportY !== 11'sd40) begin
            bad++; $display("FAIL tele_hold got=(%0d,%0d) want=(320,40)", teleportX, teleportY);
        end

        do_reset();
        key_pulse();
        sof_pulse();
        tick();
        collision = 1'b1;
        tick();
        collision = 1'b0;
        total++; if (teleport !== 1'b1) begin bad++; $display("FAIL tele_cheat_pulse got=%0b want=1", teleport); end
        total++; if (teleportX !== 11'sd100 || teleportY !== 11'sd40) begin
            bad++; $display("FAIL tele_cheat_dest got=(%0d,%0d) want=(100,40)", teleportX, teleportY);
        end
    endtask

    task automatic test_cooldown();
        int extra;
        do_reset();
        collision = 1'b1;
        tick();
        total++; if (teleport !== 1'b1) begin bad++; $display("FAIL cool_first got=%0b want=1", teleport); end
        // This frame pulse lands in the teleport cycle and must not count.
        sof_pulse();
        extra = 0;
        for (int f = 0; f < 3; f++) begin
            repeat (3) begin
                if (teleport === 1'b1) extra++;
                tick();
            end
            if (teleport === 1'b1) extra++;
            sof_pulse();
        end
        total++; if (extra != 0) begin bad++; $display("FAIL cool_early got=%0d want=0", extra); end
        total++; if (teleport !== 1'b0) begin bad++; $display("FAIL cool_after3_c1 got=%0b want=0", teleport); end
        tick();
        total++; if (teleport !== 1'b1) begin bad++; $display("FAIL cool_second got=%0b want=1", teleport); end
        collision = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        sof_pulse();
        tick();
        total++; if (topLeftX_Original !== 11'sd64) begin bad++; $display("FAIL b2b_premove got=%0d want=64", topLeftX_Original); end
        startOfFrame = 1'b1;
        collision    = 1'b1;
        tick();
        startOfFrame = 1'b0;
        collision    = 1'b0;
        total++; if (topLeftX_Original !== 11'sd68) begin bad++; $display("FAIL b2b_x got=%0d want=68", topLeftX_Original); end
        total++; if (teleport !== 1'b1) begin bad++; $display("FAIL b2b_tele got=%0b want=1", teleport); end
        tick();
        total++; if (teleport !== 1'b0) begin bad++; $display("FAIL b2b_tele_end got=%0b want=0", teleport); end
    endtask

    task automatic test_reset_mid_cooldown();
        do_reset();
        key_pulse();
        sof_pulse();
        tick();
        sof_pulse();
        total++; if (topLeftX_Original !== 11'sd68 || wormholeCheat !== 1'b1) begin
            bad++; $display("FAIL rmc_setup got=(%0d,%0b) want=(68,1)", topLeftX_Original, wormholeCheat);
        end
        collision = 1'b1;
        tick();
        collision = 1'b0;
        tick();
        sof_pulse();
        collision = 1'b1;
        resetN    = 1'b1;
        tick();
        total++; if (teleport !== 1'b0) begin bad++; $display("FAIL rmc_tele got=%0b want=0", teleport); end
        total++; if (topLeftX_Original !== 11'sd64) begin bad++; $display("FAIL rmc_x got=%0d want=64", topLeftX_Original); end
        total++; if (wormholeCheat !== 1'b0) begin bad++; $display("FAIL rmc_cheat got=%0b want=0", wormholeCheat); end
        resetN = 1'b0;
        tick();
        collision = 1'b0;
        total++; if (teleport !== 1'b1) begin bad++; $display("FAIL rmc_accept got=%0b want=1", teleport); end
        total++; if (teleportX !== 11'sd320 || teleportY !== 11'sd40) begin
            bad++; $display("FAIL rmc_dest got=(%0d,%0d) want=(320,40)", teleportX, teleportY);
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_cheat_toggle();
        test_teleport();
        test_cooldown();
        test_back_to_back();
        test_reset_mid_cooldown();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
